// File: rtl/echo_delay_ctrl.sv
// Echo engine driving a circular BRAM delay line: reads the delayed sample,
// mixes it into the wet output and writes dry+feedback back at the write pointer.
module echo_delay_ctrl #(
  parameter int ADDR_WIDTH = 8,
  parameter int DATA_WIDTH = 12,
  parameter int GAIN_WIDTH = 8
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  in_valid,
  input  logic [DATA_WIDTH-1:0] in_sample,
  input  logic [ADDR_WIDTH-1:0] delay_len,
  input  logic [GAIN_WIDTH-1:0] fb_gain,
  input  logic [GAIN_WIDTH-1:0] mix_gain,
  output logic                  out_valid,
  output logic [DATA_WIDTH-1:0] out_sample,
  output logic                  busy,
  output logic                  overrun,
  output logic [ADDR_WIDTH-1:0] ram_rd_addr,
  output logic [ADDR_WIDTH-1:0] ram_wr_addr,
  output logic                  ram_wr_en,
  output logic [DATA_WIDTH-1:0] ram_wr_data,
  input  logic [DATA_WIDTH-1:0] ram_rd_data
);
  localparam int PW = DATA_WIDTH + GAIN_WIDTH + 1;
  localparam logic signed [PW:0] SMAX = (PW+1)'((1 << (DATA_WIDTH-1)) - 1);
  localparam logic signed [PW:0] SMIN = -SMAX - 1;

  typedef enum logic [1:0] {CLEAR, IDLE, WAIT, MIX} state_t;

  state_t                state;
  logic [ADDR_WIDTH:0]   clr_cnt;
  logic [ADDR_WIDTH-1:0] wr_ptr;
  logic [DATA_WIDTH-1:0] x_q;
  logic [GAIN_WIDTH-1:0] fb_q, mix_q;

  logic signed [PW-1:0] d_ext, mix_ext, fb_ext, mix_p, fb_p;
  logic signed [PW:0]   x_ext, out_sum, wr_sum;

  function automatic logic [DATA_WIDTH-1:0] sat(input logic signed [PW:0] v);
    if (v > SMAX)      sat = SMAX[DATA_WIDTH-1:0];
    else if (v < SMIN) sat = SMIN[DATA_WIDTH-1:0];
    else               sat = v[DATA_WIDTH-1:0];
  endfunction

  // Gains are unsigned, so zero-extend them before the signed multiply.
  always_comb begin
    d_ext   = {{(GAIN_WIDTH+1){ram_rd_data[DATA_WIDTH-1]}}, ram_rd_data};
    mix_ext = {{(DATA_WIDTH+1){1'b0}}, mix_q};
    fb_ext  = {{(DATA_WIDTH+1){1'b0}}, fb_q};
    mix_p   = d_ext * mix_ext;
    fb_p    = d_ext * fb_ext;
    x_ext   = {{(GAIN_WIDTH+2){x_q[DATA_WIDTH-1]}}, x_q};
    out_sum = x_ext + {mix_p[PW-1], mix_p >>> GAIN_WIDTH};
    wr_sum  = x_ext + {fb_p[PW-1], fb_p >>> GAIN_WIDTH};
  end

  assign busy = (state != IDLE);

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state       <= CLEAR;
      clr_cnt     <= '0;
      wr_ptr      <= '0;
      x_q         <= '0;
      fb_q        <= '0;
      mix_q       <= '0;
      out_valid   <= 1'b0;
      out_sample  <= '0;
      overrun     <= 1'b0;
      ram_rd_addr <= '0;
      ram_wr_addr <= '0;
      ram_wr_en   <= 1'b0;
      ram_wr_data <= '0;
    end else begin
      ram_wr_en <= 1'b0;
      out_valid <= 1'b0;
      if (in_valid && state != IDLE) overrun <= 1'b1;
      case (state)
        CLEAR: begin
          // Extra top bit of clr_cnt marks the sweep done after the last address.
          if (clr_cnt[ADDR_WIDTH]) begin
            state <= IDLE;
          end else begin
            ram_wr_en   <= 1'b1;
            ram_wr_addr <= clr_cnt[ADDR_WIDTH-1:0];
            ram_wr_data <= '0;
            clr_cnt     <= clr_cnt + 1'b1;
          end
        end
        IDLE: begin
          if (in_valid) begin
            x_q         <= in_sample;
            fb_q        <= fb_gain;
            mix_q       <= mix_gain;
            ram_rd_addr <= wr_ptr - delay_len;
            state       <= WAIT;
          end
        end
        WAIT: state <= MIX;
        MIX: begin
          out_sample  <= sat(out_sum);
          ram_wr_data <= sat(wr_sum);
          ram_wr_addr <= wr_ptr;
          ram_wr_en   <= 1'b1;
          out_valid   <= 1'b1;
          wr_ptr      <= wr_ptr + 1'b1;
          state       <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_echo_delay_ctrl.sv
// Bench for echo_delay_ctrl with a read-first BRAM model and an
// array-based reference of the delay line (depth 16).
module tb_echo_delay_ctrl;
  localparam int AW = 4, DW = 12, GW = 8, DEPTH = 16;

  logic clk = 1'b0, rst_n = 1'b0, in_valid = 1'b0;
  logic [DW-1:0] in_sample = '0;
  logic [AW-1:0] delay_len = '0;
  logic [GW-1:0] fb_gain = '0, mix_gain = '0;
  logic out_valid, busy, overrun, ram_wr_en;
  logic [DW-1:0] out_sample, ram_wr_data, ram_rd_data;
  logic [AW-1:0] ram_rd_addr, ram_wr_addr;
  logic junk_en = 1'b0;
  logic [DW-1:0] mem [DEPTH];

  int cmp = 0, fails = 0;
  int line [DEPTH];
  int wp = 0;

  echo_delay_ctrl #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .GAIN_WIDTH(GW)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_sample(in_sample),
    .delay_len(delay_len), .fb_gain(fb_gain), .mix_gain(mix_gain),
    .out_valid(out_valid), .out_sample(out_sample), .busy(busy), .overrun(overrun),
    .ram_rd_addr(ram_rd_addr), .ram_wr_addr(ram_wr_addr), .ram_wr_en(ram_wr_en),
    .ram_wr_data(ram_wr_data), .ram_rd_data(ram_rd_data));

  always #5 clk = ~clk;

  // Read-first BRAM; junk_en scribbles over it so the clear sweep is observable.
  always @(posedge clk) begin
    ram_rd_data <= mem[ram_rd_addr];
    if (junk_en) for (int i = 0; i < DEPTH; i++) mem[i] <= DW'($urandom_range(1, 4095));
    else if (ram_wr_en) mem[ram_wr_addr] <= ram_wr_data;
  end

  typedef struct {
    bit early; bit timeout; logic vld; logic wen;
    logic [AW-1:0] addr; logic [DW-1:0] wdata; logic [DW-1:0] out;
  } obs_t;

  function automatic int clamp(input int v);
    return (v > 2047) ? 2047 : (v < -2048) ? -2048 : v;
  endfunction

  // Reference: the delay line as a plain array indexed by sample count.
  task automatic ref_step(input int x, input int dl, input int fg, input int mg,
                          output int eo, output int ew, output int ea);
    int d;
    d  = line[(wp - dl + DEPTH) % DEPTH];
    eo = clamp(x + ((d * mg) >>> GW));
    ew = clamp(x + ((d * fg) >>> GW));
    ea = wp;
    line[wp] = ew;
    wp = (wp + 1) % DEPTH;
  endtask

  task automatic apply_reset();
    int n = 0;
    @(negedge clk); rst_n = 1'b0; in_valid = 1'b0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    while (busy && n < 100) begin @(negedge clk); n++; end
    for (int i = 0; i < DEPTH; i++) line[i] = 0;
    wp = 0;
  endtask

  // Offers one sample when idle and records what the DUT does over 3 edges.
  task automatic drive(input int x, input int dl, input int fg, input int mg, output obs_t o);
    int n = 0;
    o = '{default: 0};
    while (busy && n < 400) begin @(negedge clk); n++; end
    o.timeout = busy;
    in_valid = 1'b1; in_sample = DW'(x); delay_len = AW'(dl);
    fb_gain = GW'(fg); mix_gain = GW'(mg);
    @(posedge clk); #1 in_valid = 1'b0; o.early = out_valid | ram_wr_en;
    @(posedge clk); #1 o.early = o.early | out_valid | ram_wr_en;
    @(posedge clk); #1
    o.vld = out_valid; o.wen = ram_wr_en; o.addr = ram_wr_addr;
    o.wdata = ram_wr_data; o.out = out_sample;
    @(negedge clk);
  endtask

  task automatic test_reset();
    int nz = 0;
    rst_n = 1'b0; junk_en = 1'b1;
    @(negedge clk); junk_en = 1'b0;
    @(negedge clk);
    cmp++;
    if ({out_valid, ram_wr_en, overrun, out_sample, ram_rd_addr, ram_wr_addr, ram_wr_data, busy}
        !== {3'b0, 12'd0, 4'd0, 4'd0, 12'd0, 1'b1}) begin
      fails++;
      $display("FAIL reset_state: ov=%0b we=%0b orun=%0b out=%0d busy=%0b, want zeros with busy=1",
               out_valid, ram_wr_en, overrun, out_sample, busy);
    end
    rst_n = 1'b1;
    for (int c = 0; c < DEPTH; c++) begin
      @(posedge clk); #1;
      cmp++;
      if (ram_wr_en !== 1'b1 || ram_wr_addr !== AW'(c) || ram_wr_data !== '0 || busy !== 1'b1) begin
        fails++;
        $display("FAIL clear_sweep[%0d]: we=%0b addr=%0d data=%0d busy=%0b, want we=1 addr=%0d data=0 busy=1",
                 c, ram_wr_en, ram_wr_addr, ram_wr_data, busy, c);
      end
    end
    @(posedge clk); #1;
    cmp++;
    if (ram_wr_en !== 1'b0 || busy !== 1'b0) begin
      fails++;
      $display("FAIL clear_end: we=%0b busy=%0b, want 0 0", ram_wr_en, busy);
    end
    for (int i = 0; i < DEPTH; i++) if (mem[i] != '0) nz++;
    cmp++;
    if (nz != 0) begin
      fails++;
      $display("FAIL clear_mem: %0d nonzero words, want 0", nz);
    end
    for (int i = 0; i < DEPTH; i++) line[i] = 0;
    wp = 0;
  endtask

  task automatic test_echo();
    int xs [5] = '{1000, 0, 0, 0, 0};
    int eo [5] = '{1000, 0, 0, 500, 0};
    obs_t o;
    apply_reset();
    for (int n = 0; n < 5; n++) begin
      drive(xs[n], 3, 0, 128, o);
      cmp++;
      if (o.timeout || o.early || {o.vld, o.wen, o.addr, o.wdata, o.out} !== {2'b11, AW'(n), DW'(xs[n]), DW'(eo[n])}) begin
        fails++;
        $display("FAIL echo[%0d]: vld=%0b we=%0b addr=%0d wdata=%0d out=%0d early=%0b, want addr=%0d wdata=%0d out=%0d",
                 n, o.vld, o.wen, o.addr, $signed(o.wdata), $signed(o.out), o.early, n, xs[n], eo[n]);
      end
    end
  endtask

  task automatic test_feedback();
    int ev [7] = '{1024, 0, 512, 0, 256, 0, 128};
    obs_t o;
    apply_reset();
    for (int n = 0; n < 7; n++) begin
      drive((n == 0) ? 1024 : 0, 2, 128, 128, o);
      cmp++;
      if (o.timeout || o.early || {o.vld, o.wen, o.wdata, o.out} !== {2'b11, DW'(ev[n]), DW'(ev[n])}) begin
        fails++;
        $display("FAIL feedback[%0d]: vld=%0b we=%0b wdata=%0d out=%0d, want wdata=%0d out=%0d",
                 n, o.vld, o.wen, $signed(o.wdata), $signed(o.out), ev[n], ev[n]);
      end
    end
  endtask

  task automatic test_saturation();
    int xs [6] = '{2047, 2047, -2048, -2048, -1, 0};
    int mg [6] = '{0, 255, 0, 255, 0, 128};
    int eo [6] = '{2047, 2047, -2048, -2048, -1, -1};
    obs_t o;
    apply_reset();
    for (int n = 0; n < 6; n++) begin
      drive(xs[n], 1, 0, mg[n], o);
      cmp++;
      if (o.timeout || o.vld !== 1'b1 || o.out !== DW'(eo[n]) || o.wdata !== DW'(xs[n])) begin
        fails++;
        $display("FAIL saturation[%0d]: vld=%0b out=%0d wdata=%0d, want out=%0d wdata=%0d",
                 n, o.vld, $signed(o.out), $signed(o.wdata), eo[n], xs[n]);
      end
    end
  endtask

  task automatic test_wrap();
    obs_t o;
    int e;
    apply_reset();
    for (int n = 1; n <= 40; n++) begin
      drive(n, 0, 0, 128, o);
      e = (n >= 17) ? n + ((n - 16) >>> 1) : n;
      cmp++;
      if (o.timeout || o.vld !== 1'b1 || o.out !== DW'(e) || o.addr !== AW'((n - 1) % DEPTH)) begin
        fails++;
        $display("FAIL wrap[%0d]: vld=%0b out=%0d addr=%0d, want out=%0d addr=%0d",
                 n, o.vld, $signed(o.out), o.addr, e, (n - 1) % DEPTH);
      end
    end
  endtask

  task automatic test_random();
    obs_t o;
    int x, dl, fg, mg, eo, ew, ea;
    apply_reset();
    for (int n = 0; n < 60; n++) begin
      x  = int'($urandom_range(0, 4095)) - 2048;
      dl = int'($urandom_range(0, 15));
      fg = int'($urandom_range(0, 255));
      mg = int'($urandom_range(0, 255));
      ref_step(x, dl, fg, mg, eo, ew, ea);
      drive(x, dl, fg, mg, o);
      cmp++;
      if (o.timeout || o.early || {o.vld, o.wen, o.addr, o.wdata, o.out} !== {2'b11, AW'(ea), DW'(ew), DW'(eo)}) begin
        fails++;
        $display("FAIL random[%0d]: vld=%0b we=%0b addr=%0d wdata=%0d out=%0d, want addr=%0d wdata=%0d out=%0d",
                 n, o.vld, o.wen, o.addr, $signed(o.wdata), $signed(o.out), ea, ew, eo);
      end
    end
  endtask

  task automatic test_back_to_back();
    int n = 0, nv = 0, eo, ew, ea;
    logic [DW-1:0] got = '0;
    while (busy && n < 100) begin @(negedge clk); n++; end
    ref_step(300, 5, 64, 200, eo, ew, ea);
    in_valid = 1'b1; in_sample = DW'(300); delay_len = 4'd5; fb_gain = 8'd64; mix_gain = 8'd200;
    @(posedge clk); #1 in_sample = DW'(-700);
    @(posedge clk); #1 in_valid = 1'b0;
    for (int c = 0; c < 8; c++) begin
      @(posedge clk); #1;
      if (out_valid) begin nv++; got = out_sample; end
    end
    cmp++;
    if (nv != 1 || overrun !== 1'b1 || got !== DW'(eo)) begin
      fails++;
      $display("FAIL back_to_back: out_valid count=%0d overrun=%0b out=%0d, want 1 1 %0d",
               nv, overrun, $signed(got), eo);
    end
  endtask

  task automatic test_mid_reset();
    int nv = 0, nw = 0, nbad = 0;
    @(negedge clk);
    in_valid = 1'b1; in_sample = DW'(555); delay_len = 4'd1;
    @(posedge clk); #1 in_valid = 1'b0;
    @(negedge clk); rst_n = 1'b0;
    @(posedge clk); #1;
    cmp++;
    if (out_valid !== 1'b0 || ram_wr_en !== 1'b0 || overrun !== 1'b0) begin
      fails++;
      $display("FAIL mid_reset: ov=%0b we=%0b overrun=%0b, want 0 0 0", out_valid, ram_wr_en, overrun);
    end
    @(negedge clk); rst_n = 1'b1;
    for (int c = 0; c < 20; c++) begin
      @(posedge clk); #1;
      if (out_valid) nv++;
      if (ram_wr_en) begin
        if (ram_wr_addr !== AW'(nw) || ram_wr_data !== '0) nbad++;
        nw++;
      end
    end
    cmp++;
    if (nv != 0 || nw != DEPTH || nbad != 0 || busy !== 1'b0) begin
      fails++;
      $display("FAIL mid_reset_sweep: out_valids=%0d writes=%0d bad=%0d busy=%0b, want 0 16 0 0",
               nv, nw, nbad, busy);
    end
  endtask

  initial begin
    test_reset();
    test_echo();
    test_feedback();
    test_saturation();
    test_wrap();
    test_random();
    test_back_to_back();
    test_mid_reset();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", cmp, fails);
    $finish;
  end
endmodule
